// File: rtl/bp_ctrl_pkg.sv
// Shared types and default sizing for the belief-propagation iteration controller.
package bp_ctrl_pkg;

   localparam int ITER_W          = 4;
   localparam int MAX_ITER_DEF    = 10;
   localparam int LOAD_CYCLES_DEF = 16;
   localparam int ADDR_W_DEF      = 4;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_VN_GO,
      ST_VN_WAIT,
      ST_CN_GO,
      ST_CN_WAIT,
      ST_SYN_GO,
      ST_SYN_WAIT,
      ST_FINISH
   } bp_state_e;

endpackage

// File: rtl/bp_load_sequencer.sv
// Channel-LLR load sequencer: one write-enabled address per cycle, 0..LOAD_CYCLES-1.
module bp_load_sequencer #(
   parameter int LOAD_CYCLES = bp_ctrl_pkg::LOAD_CYCLES_DEF,
   parameter int ADDR_W      = bp_ctrl_pkg::ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start_i,
   input  logic              abort_i,
   output logic              load_en_o,
   output logic [ADDR_W-1:0] load_addr_o,
   output logic              last_o
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LOAD_CYCLES - 1);

   logic              load_en_q,   load_en_d;
   logic [ADDR_W-1:0] load_addr_q, load_addr_d;

   assign last_o = load_en_q && (load_addr_q == LAST_ADDR);

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      load_en_d   = load_en_q;
      load_addr_d = load_addr_q;
      if (start_i) begin
         load_en_d   = 1'b1;
         load_addr_d = '0;
      end else if (load_en_q) begin
         if (abort_i || last_o) begin
            load_en_d   = 1'b0;
            load_addr_d = '0;
         end else begin
            load_addr_d = load_addr_q + ADDR_W'(1);
         end
      end
   end

   // NOTE: state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         load_en_q   <= 1'b0;
         load_addr_q <= '0;
      end else begin
         load_en_q   <= load_en_d;
         load_addr_q <= load_addr_d;
      end
   end

   assign load_en_o   = load_en_q;
   assign load_addr_o = load_addr_q;

endmodule

// File: rtl/bp_iteration_controller.sv
// Belief-propagation decode sequencer: LLR load, then VN/CN/syndrome per iteration
// until the syndrome passes, the iteration limit is hit, or abort.
module bp_iteration_controller #(
   parameter int MAX_ITER    = bp_ctrl_pkg::MAX_ITER_DEF,
   parameter int ITER_W      = bp_ctrl_pkg::ITER_W,
   parameter int LOAD_CYCLES = bp_ctrl_pkg::LOAD_CYCLES_DEF,
   parameter int ADDR_W      = bp_ctrl_pkg::ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   output logic              load_en,
   output logic [ADDR_W-1:0] load_addr,
   output logic              vn_start,
   input  logic              vn_done,
   output logic              cn_start,
   input  logic              cn_done,
   output logic              syn_start,
   input  logic              syn_done,
   input  logic              syn_ok,
   output logic              iter_clr,
   output logic              iter_inc,
   output logic [ITER_W-1:0] iter_count,
   output logic              busy,
   output logic              done,
   output logic              converged
);

   import bp_ctrl_pkg::*;

   bp_state_e         state_q, state_d;
   logic [ITER_W-1:0] iter_count_q, iter_count_d;
   logic              converged_q, converged_d;
   logic              iter_inc_d;
   logic              accept;
   logic              abort_hit;
   logic              load_last;

   logic vn_start_q, cn_start_q, syn_start_q;
   logic iter_clr_q, iter_inc_q, busy_q, done_q;

   bp_load_sequencer #(
      .LOAD_CYCLES (LOAD_CYCLES),
      .ADDR_W      (ADDR_W)
   ) u_load_seq (
      .clk         (clk),
      .reset_n     (reset_n),
      .start_i     (accept),
      .abort_i     (abort_hit),
      .load_en_o   (load_en),
      .load_addr_o (load_addr),
      .last_o      (load_last)
   );

   always_comb begin
      state_d      = state_q;
      iter_count_d = iter_count_q;
      converged_d  = converged_q;
      iter_inc_d   = 1'b0;
      accept       = 1'b0;
      abort_hit    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               accept       = 1'b1;
               iter_count_d = '0;
               converged_d  = 1'b0;
               state_d      = ST_LOAD;
            end
         end
         ST_LOAD:     if (load_last) state_d = ST_VN_GO;
         ST_VN_GO:    state_d = ST_VN_WAIT;
         ST_VN_WAIT:  if (vn_done) state_d = ST_CN_GO;
         ST_CN_GO:    state_d = ST_CN_WAIT;
         ST_CN_WAIT:  if (cn_done) state_d = ST_SYN_GO;
         ST_SYN_GO:   state_d = ST_SYN_WAIT;
         ST_SYN_WAIT: begin
            if (syn_done) begin
               if (syn_ok) begin
                  converged_d = 1'b1;
                  state_d     = ST_FINISH;
               end else begin
                  iter_inc_d   = 1'b1;
                  iter_count_d = iter_count_q + ITER_W'(1);
                  state_d      = (iter_count_d == ITER_W'(MAX_ITER)) ? ST_FINISH : ST_VN_GO;
               end
            end
         end
         ST_FINISH:   state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase

      // FINISH is already reporting the outcome, so abort there must not add a second done.
      if (abort && (state_q != ST_IDLE) && (state_q != ST_FINISH)) begin
         abort_hit    = 1'b1;
         state_d      = ST_IDLE;
         iter_count_d = iter_count_q;
         iter_inc_d   = 1'b0;
         converged_d  = 1'b0;
      end
   end

   // Outputs are registered from next-state so they line up with the state they describe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         iter_count_q <= '0;
         converged_q  <= 1'b0;
         vn_start_q   <= 1'b0;
         cn_start_q   <= 1'b0;
         syn_start_q  <= 1'b0;
         iter_clr_q   <= 1'b0;
         iter_inc_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         iter_count_q <= iter_count_d;
         converged_q  <= converged_d;
         vn_start_q   <= (state_d == ST_VN_GO);
         cn_start_q   <= (state_d == ST_CN_GO);
         syn_start_q  <= (state_d == ST_SYN_GO);
         iter_clr_q   <= accept;
         iter_inc_q   <= iter_inc_d;
         busy_q       <= (state_d != ST_IDLE);
         done_q       <= (state_d == ST_FINISH) || abort_hit;
      end
   end

   assign vn_start   = vn_start_q;
   assign cn_start   = cn_start_q;
   assign syn_start  = syn_start_q;
   assign iter_clr   = iter_clr_q;
   assign iter_inc   = iter_inc_q;
   assign iter_count = iter_count_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign converged  = converged_q;

endmodule

// File: tb/tb_bp_iteration_controller.sv
// Directed bench for bp_iteration_controller with modelled VN/CN/syndrome units.
module tb_bp_iteration_controller;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic       abort;
   logic       load_en;
   logic [3:0] load_addr;
   logic       vn_start, cn_start, syn_start;
   logic       vn_done = 1'b0, cn_done = 1'b0, syn_done = 1'b0, syn_ok = 1'b0;
   logic       iter_clr, iter_inc;
   logic [3:0] iter_count;
   logic       busy, done, converged;

   logic [16:0] all_outs;
   assign all_outs = {load_en, load_addr, vn_start, cn_start, syn_start,
                      iter_clr, iter_inc, iter_count, busy, done, converged};

   int total = 0;
   int bad   = 0;

   // Unit-model configuration, written only by the main sequence.
   int cfg_dly    = 1;
   int cfg_ok     = 0;
   bit cfg_glitch = 1'b0;

   // Per-run counters, restarted whenever iter_clr is seen.
   int clr_total = 0;
   int n_vn, n_cn, n_syn, n_inc, n_load, n_done;
   int exp_addr;
   int vn_pend, cn_pend, syn_pend, syn_seen;

   bp_iteration_controller dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .abort      (abort),
      .load_en    (load_en),
      .load_addr  (load_addr),
      .vn_start   (vn_start),
      .vn_done    (vn_done),
      .cn_start   (cn_start),
      .cn_done    (cn_done),
      .syn_start  (syn_start),
      .syn_done   (syn_done),
      .syn_ok     (syn_ok),
      .iter_clr   (iter_clr),
      .iter_inc   (iter_inc),
      .iter_count (iter_count),
      .busy       (busy),
      .done       (done),
      .converged  (converged)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Monitor plus unit models: act on the falling edge, done answers cfg_dly cycles after *_start.
   initial begin
      forever begin
         @(negedge clk);
         vn_done  = 1'b0;
         cn_done  = 1'b0;
         syn_done = 1'b0;
         syn_ok   = 1'b0;
         if (!reset_n) begin
            vn_pend  = 0;
            cn_pend  = 0;
            syn_pend = 0;
            continue;
         end
         if (iter_clr) begin
            clr_total++;
            n_vn = 0; n_cn = 0; n_syn = 0; n_inc = 0; n_load = 0; n_done = 0;
            exp_addr = 0;
            syn_seen = 0;
         end
         if (load_en) begin
            check("load_addr", 32'(load_addr), exp_addr);
            exp_addr++;
            n_load++;
         end
         if (vn_start)  n_vn++;
         if (cn_start)  n_cn++;
         if (syn_start) n_syn++;
         if (iter_inc)  n_inc++;
         if (done)      n_done++;

         if (vn_pend > 0) begin
            vn_pend--;
            if (vn_pend == 0) vn_done = 1'b1;
         end
         if (cn_pend > 0) begin
            cn_pend--;
            if (cn_pend == 0) cn_done = 1'b1;
            if (cfg_glitch && cn_pend == cfg_dly - 1) vn_done = 1'b1;
         end
         if (syn_pend > 0) begin
            syn_pend--;
            if (syn_pend == 0) begin
               syn_done = 1'b1;
               syn_seen++;
               syn_ok = (syn_seen == cfg_ok);
            end
         end
         if (vn_start)  vn_pend = cfg_dly;
         if (cn_start) begin
            cn_pend = cfg_dly;
            if (cfg_glitch) cn_done = 1'b1;
         end
         if (syn_start) syn_pend = cfg_dly;
      end
   end

   // lat counts cycles after the start cycle until done is seen; the start cycle itself is cycle 0.
   task automatic run_decode(input int dly, input int ok_at, input bit glitch, input bit abort_too,
                             output int lat, output logic conv, output logic [3:0] icnt);
      int base_clr;
      cfg_dly    = dly;
      cfg_ok     = ok_at;
      cfg_glitch = glitch;
      base_clr   = clr_total;
      start      = 1'b1;
      abort      = abort_too;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("accept_busy", 32'(busy), 1);
      check("accept_iter_clr", clr_total, base_clr + 1);
      lat  = 0;
      conv = 1'bx;
      icnt = 'x;
      for (int m = 1; m <= 3000; m++) begin
         start = (glitch && m == 30);
         if (done) begin
            lat  = m;
            conv = converged;
            icnt = iter_count;
            break;
         end
         tick();
      end
      start = 1'b0;
      check("finish_busy", 32'(busy), 1);
   endtask

   initial begin
      int         lat;
      logic       conv;
      logic [3:0] icnt;
      bit         found;

      reset_n = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      repeat (2) tick();
      check("reset_outputs", 32'(all_outs), 0);
      reset_n = 1'b1;
      repeat (2) tick();
      check("idle_outputs", 32'(all_outs), 0);

      // Converge on the first syndrome check, units answer 3 cycles after each start.
      run_decode(3, 1, 1'b0, 1'b0, lat, conv, icnt);
      check("t1_latency", lat, 29);
      check("t1_converged", 32'(conv), 1);
      check("t1_iter_count", 32'(icnt), 0);
      check("t1_iter_inc", n_inc, 0);
      check("t1_load_cycles", n_load, 16);
      check("t1_vn_starts", n_vn, 1);
      check("t1_syn_starts", n_syn, 1);
      tick();
      check("t1_busy_low", 32'(busy), 0);
      check("t1_done_once", n_done, 1);

      // Abort while idle does nothing; the previous result stays visible.
      abort = 1'b1;
      repeat (3) tick();
      check("idle_abort_busy", 32'(busy), 0);
      check("idle_abort_done", 32'(done), 0);
      check("idle_abort_conv_held", 32'(converged), 1);
      abort = 1'b0;

      // Never converges: ten full iterations with zero-wait units.
      run_decode(1, 0, 1'b0, 1'b0, lat, conv, icnt);
      check("t2_latency", lat, 77);
      check("t2_converged", 32'(conv), 0);
      check("t2_iter_count", 32'(icnt), 10);
      check("t2_iter_inc", n_inc, 10);
      check("t2_vn_starts", n_vn, 10);
      check("t2_cn_starts", n_cn, 10);
      check("t2_syn_starts", n_syn, 10);
      tick();
      check("t2_busy_low", 32'(busy), 0);

      // Converge on iteration 4, start and abort together in IDLE; done in cycle 42 counting start as cycle 1.
      run_decode(1, 4, 1'b0, 1'b1, lat, conv, icnt);
      check("t3_latency", lat, 41);
      check("t3_converged", 32'(conv), 1);
      check("t3_iter_count", 32'(icnt), 3);
      check("t3_iter_inc", n_inc, 3);
      check("t3_vn_starts", n_vn, 4);
      repeat (3) tick();
      check("t3_conv_held", 32'(converged), 1);
      check("t3_done_once", n_done, 1);

      // Abort in CN_WAIT of iteration 2, colliding with cn_done.
      cfg_dly    = 3;
      cfg_ok     = 0;
      cfg_glitch = 1'b0;
      start      = 1'b1;
      tick();
      start = 1'b0;
      found = 1'b0;
      for (int m = 0; m < 200; m++) begin
         if (n_cn == 2) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      check("t4_reached_cn2", 32'(found), 1);
      check("t4_cn_start", 32'(cn_start), 1);
      repeat (3) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t4_busy", 32'(busy), 0);
      check("t4_done", 32'(done), 1);
      check("t4_converged", 32'(converged), 0);
      check("t4_iter_count", 32'(iter_count), 1);
      repeat (4) tick();
      check("t4_no_syn_start", n_syn, 1);
      check("t4_done_once", n_done, 1);
      check("t4_idle_done_low", 32'(done), 0);

      // Spurious handshakes: cn_done in CN_GO, vn_done in CN_WAIT, start while busy.
      run_decode(3, 2, 1'b1, 1'b0, lat, conv, icnt);
      check("t5_latency", lat, 41);
      check("t5_converged", 32'(conv), 1);
      check("t5_iter_count", 32'(icnt), 1);
      check("t5_iter_inc", n_inc, 1);
      check("t5_cn_starts", n_cn, 2);
      check("t5_syn_starts", n_syn, 2);
      check("t5_load_cycles", n_load, 16);
      repeat (3) tick();
      check("t5_start_not_queued", 32'(busy), 0);

      // Reset in the middle of LOAD, then a clean run.
      cfg_glitch = 1'b0;
      cfg_dly    = 1;
      cfg_ok     = 1;
      start      = 1'b1;
      tick();
      start = 1'b0;
      found = 1'b0;
      for (int m = 0; m < 40; m++) begin
         if (load_en && load_addr == 4'd7) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      check("t6_reached_addr7", 32'(found), 1);
      reset_n = 1'b0;
      #1;
      check("t6_async_reset", 32'(all_outs), 0);
      repeat (2) tick();
      check("t6_reset_hold", 32'(all_outs), 0);
      reset_n = 1'b1;
      tick();
      run_decode(1, 1, 1'b0, 1'b0, lat, conv, icnt);
      check("t6_latency", lat, 23);
      check("t6_load_cycles", n_load, 16);
      check("t6_converged", 32'(conv), 1);
      check("t6_iter_count", 32'(icnt), 0);
      tick();
      check("t6_busy_low", 32'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
